afifo_rd_downsizer: RTL and testbench

Read-side consumer of the dual-clock FIFO: pops first-word-fall-through (FWFT) words from the FIFO read port and serializes each one into C_RATIO narrower beats on a valid/ready stream. Sits in the read clock domain directly downstream of the clock-crossing FIFO, between the wide PHY-rate data path and the NASTI-side response logic. Sustains one beat per cycle with no bubbles between FIFO words.

---
 rtl/afifo_rd_downsizer.sv | 110 +++++++++++
 tb/tb_afifo_rd_downsizer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_downsizer.sv
// Pops FWFT words from the dual-clock FIFO read port and serializes each into C_RATIO beats.
// Optional accepted-beat counter enabled by defining AFIFO_RD_DOWNSIZER_BEAT_COUNT_EN.
module afifo_rd_downsizer #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_RATIO      = 4
) (
    input  logic                            rclk,
    input  logic                            rrstn,
    input  logic [C_RATIO*C_DATA_WIDTH:0]   fifo_rdata,
    input  logic                            fifo_rempty,
    output logic                            fifo_rden,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [C_DATA_WIDTH-1:0]         m_data,
    output logic                            m_last,
    output logic [31:0]                     beat_count
);

    localparam int WORD_W = C_RATIO * C_DATA_WIDTH;
    localparam int IDX_W  = (C_RATIO > 1) ? $clog2(C_RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_RATIO - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                last_q, last_d;
    logic                held;
    logic                drain;
    logic [C_DATA_WIDTH-1:0] beat_sel;

    // A new word may be popped only when the held word is gone or leaves this cycle.
    always_comb begin
        held      = (state_q == ST_HOLD);
        drain     = held & m_ready & (idx_q == LAST_IDX);
        fifo_rden = ~fifo_rempty & (~held | drain);

        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        last_d  = last_q;

        if (fifo_rden) begin
            word_d  = fifo_rdata[WORD_W-1:0];
            last_d  = fifo_rdata[WORD_W];
            state_d = ST_HOLD;
            idx_d   = '0;
        end else if (drain) begin
            state_d = ST_EMPTY;
            idx_d   = '0;
        end else if (held & m_ready) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        beat_sel = '0;
        for (int i = 0; i < C_RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                beat_sel = word_q[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
        end
        m_valid = held;
        m_data  = beat_sel;
        m_last  = last_q & (idx_q == LAST_IDX);
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

`ifdef AFIFO_RD_DOWNSIZER_BEAT_COUNT_EN
    logic [31:0] count_q, count_d;

    // Saturating count of accepted beats.
    always_comb begin
        count_d = count_q;
        if (m_valid & m_ready & (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            count_q <= 32'h0;
        end else begin
            count_q <= count_d;
        end
    end

    assign beat_count = count_q;
`else
    assign beat_count = 32'h0;
`endif

endmodule

// File: tb/tb_afifo_rd_downsizer.sv
// Self-checking bench for afifo_rd_downsizer: queue-based reference model plus directed literal checks.
// A second instance covers the C_RATIO=1 register-slice build.
module tb_afifo_rd_downsizer;

`ifdef AFIFO_RD_DOWNSIZER_BEAT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        rclk;
    logic        rrstn;
    logic [32:0] fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_rden;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [31:0] beat_count;

    logic [8:0]  r1_rdata;
    logic        r1_rempty;
    logic        r1_rden;
    logic        r1_valid;
    logic        r1_ready;
    logic [7:0]  r1_data;
    logic        r1_last;
    logic [31:0] r1_count;

    afifo_rd_downsizer #(.C_DATA_WIDTH(8), .C_RATIO(4)) dut (
        .rclk(rclk), .rrstn(rrstn),
        .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty), .fifo_rden(fifo_rden),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .beat_count(beat_count)
    );

    afifo_rd_downsizer #(.C_DATA_WIDTH(8), .C_RATIO(1)) dut_r1 (
        .rclk(rclk), .rrstn(rrstn),
        .fifo_rdata(r1_rdata), .fifo_rempty(r1_rempty), .fifo_rden(r1_rden),
        .m_valid(r1_valid), .m_ready(r1_ready), .m_data(r1_data), .m_last(r1_last),
        .beat_count(r1_count)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct { logic [7:0] d; bit last; } beat_t;
    typedef struct { logic [7:0] d; bit last; int cyc; } obs_t;

    logic [32:0] srcq[$];
    logic [8:0]  src1[$];
    beat_t       beatq[$];
    obs_t        obsq[$];
    int          rdenLog[$];
    logic [31:0] mcount;
    int          cyc;
    int          checks;
    int          errors;

    bit          s1Valid, s1Last, s1Rden;
    logic [7:0]  s1Data;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput();
        bit mv, rd;
        mv = (beatq.size() != 0);
        rd = !fifo_rempty && (beatq.size() == 0 || (beatq.size() == 1 && m_ready));
        checkVal("m_valid", 64'(m_valid), 64'(mv));
        checkVal("fifo_rden", 64'(fifo_rden), 64'(rd));
        if (mv) begin
            checkVal("m_data", 64'(m_data), 64'(beatq[0].d));
            checkVal("m_last", 64'(m_last), 64'(beatq[0].last));
        end
        checkVal("beat_count", 64'(beat_count), 64'(mcount));
    endtask

    task automatic modelAdvance();
        bit acc, rd;
        logic [32:0] w;
        acc = (beatq.size() != 0) && m_ready;
        rd  = !fifo_rempty && (beatq.size() == 0 || (beatq.size() == 1 && m_ready));
        if (acc) begin
            void'(beatq.pop_front());
            if (CNT_EN && mcount != 32'hFFFF_FFFF) mcount++;
        end
        if (rd && srcq.size() != 0) begin
            w = srcq.pop_front();
            for (int i = 0; i < 4; i++) begin
                beat_t b;
                b.d    = w[i*8 +: 8];
                b.last = w[32] && (i == 3);
                beatq.push_back(b);
            end
        end
    endtask

    task automatic applyStimulus(input bit ready, input bit holdEmpty);
        @(negedge rclk);
        m_ready     = ready;
        fifo_rempty = (srcq.size() == 0) || holdEmpty;
        fifo_rdata  = (srcq.size() != 0) ? srcq[0] : 33'h0;
        r1_ready    = 1'b1;
        r1_rempty   = (src1.size() == 0);
        r1_rdata    = (src1.size() != 0) ? src1[0] : 9'h0;
        #1;
        checkOutput();
        if (m_valid && m_ready) begin
            obs_t o;
            o.d = m_data; o.last = m_last; o.cyc = cyc;
            obsq.push_back(o);
        end
        if (fifo_rden) rdenLog.push_back(cyc);
        s1Valid = r1_valid; s1Data = r1_data; s1Last = r1_last; s1Rden = r1_rden;
        if (r1_rden && src1.size() != 0) void'(src1.pop_front());
        modelAdvance();
        cyc++;
    endtask

    task automatic doReset(input int n);
        rrstn       = 1'b0;
        fifo_rempty = 1'b1;
        r1_rempty   = 1'b1;
        beatq.delete();
        srcq.delete();
        mcount = 32'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge rclk);
            #1;
            checkVal("rst m_valid", 64'(m_valid), 64'h0);
            checkVal("rst fifo_rden", 64'(fifo_rden), 64'h0);
            checkVal("rst m_data", 64'(m_data), 64'h0);
            checkVal("rst m_last", 64'(m_last), 64'h0);
            checkVal("rst beat_count", 64'(beat_count), 64'h0);
            checkVal("rst r1_valid", 64'(r1_valid), 64'h0);
        end
        @(negedge rclk);
        rrstn = 1'b1;
    endtask

    task automatic runUntilIdle(input string name, input int bound);
        int n;
        n = 0;
        while ((srcq.size() != 0 || beatq.size() != 0) && n < bound) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkVal({name, " drain timeout"}, 64'(n < bound), 64'h1);
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic clearLogs();
        obsq.delete();
        rdenLog.delete();
    endtask

    initial begin
        bit pat[12] = '{1,0,0,1,0,1,1,0,0,1,1,1};
        logic [7:0] exp1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] expBp[8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h88, 8'h77, 8'h66, 8'h55};
        bit  r1Rd[5]  = '{1,1,1,0,0};
        bit  r1Vd[5]  = '{0,1,1,1,0};
        logic [7:0] r1Dt[5] = '{8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h00};
        bit  r1Lt[5]  = '{0,0,1,0,0};
        int n;

        checks = 0; errors = 0; cyc = 0; mcount = 32'h0;
        m_ready = 1'b0; fifo_rdata = '0; fifo_rempty = 1'b1;
        r1_ready = 1'b1; r1_rdata = '0; r1_rempty = 1'b1;
        rrstn = 1'b0;

        $display("[TB] reset then idle");
        doReset(3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

        $display("[TB] single word");
        clearLogs();
        srcq.push_back({1'b1, 32'h44332211});
        runUntilIdle("single", 20);
        checkVal("single beats", 64'(obsq.size()), 64'd4);
        checkVal("single pops", 64'(rdenLog.size()), 64'd1);
        for (int i = 0; i < 4 && i < obsq.size(); i++) begin
            checkVal("single data", 64'(obsq[i].d), 64'(exp1[i]));
            checkVal("single last", 64'(obsq[i].last), 64'(i == 3));
        end
        if (obsq.size() != 0 && rdenLog.size() != 0)
            checkVal("single latency", 64'(obsq[0].cyc - rdenLog[0]), 64'd1);
        checkVal("single beat_count", 64'(beat_count), CNT_EN ? 64'd4 : 64'd0);

        $display("[TB] back-to-back");
        clearLogs();
        srcq.push_back({1'b0, 32'h0D0C0B0A});
        srcq.push_back({1'b0, 32'h1D1C1B1A});
        srcq.push_back({1'b1, 32'h2D2C2B2A});
        runUntilIdle("b2b", 40);
        checkVal("b2b beats", 64'(obsq.size()), 64'd12);
        checkVal("b2b pops", 64'(rdenLog.size()), 64'd3);
        if (rdenLog.size() == 3) begin
            checkVal("b2b pop1", 64'(rdenLog[1] - rdenLog[0]), 64'd4);
            checkVal("b2b pop2", 64'(rdenLog[2] - rdenLog[0]), 64'd8);
        end
        if (obsq.size() == 12) begin
            checkVal("b2b no bubble", 64'(obsq[11].cyc - obsq[0].cyc), 64'd11);
            checkVal("b2b last beat", 64'(obsq[11].d), 64'h2D);
        end

        $display("[TB] backpressure");
        clearLogs();
        srcq.push_back({1'b1, 32'hDDCCBBAA});
        srcq.push_back({1'b0, 32'h55667788});
        n = 0;
        while ((srcq.size() != 0 || beatq.size() != 0) && n < 80) begin
            applyStimulus(pat[n % 12], 1'b0);
            if (m_valid && m_last && !m_ready && !fifo_rempty)
                checkVal("stall final rden", 64'(fifo_rden), 64'h0);
            n++;
        end
        checkVal("bp drain timeout", 64'(n < 80), 64'h1);
        applyStimulus(1'b1, 1'b0);
        checkVal("bp beats", 64'(obsq.size()), 64'd8);
        checkVal("bp pops", 64'(rdenLog.size()), 64'd2);
        for (int i = 0; i < 8 && i < obsq.size(); i++) begin
            checkVal("bp data", 64'(obsq[i].d), 64'(expBp[i]));
            checkVal("bp last", 64'(obsq[i].last), 64'(i == 3));
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) srcq.push_back({1'($urandom_range(0, 1)), 32'($urandom)});
        n = 0;
        while ((srcq.size() != 0 || beatq.size() != 0) && n < 5000) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
            n++;
        end
        checkVal("random drain timeout", 64'(n < 5000), 64'h1);
        applyStimulus(1'b1, 1'b0);

        $display("[TB] reset mid-word");
        srcq.push_back({1'b0, 32'h88776655});
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        @(posedge rclk);
        #2;
        checkVal("pre-reset m_valid", 64'(m_valid), 64'h1);
        rrstn = 1'b0;
        fifo_rempty = 1'b1;
        #1;
        checkVal("async m_valid", 64'(m_valid), 64'h0);
        checkVal("async beat_count", 64'(beat_count), 64'h0);
        checkVal("async fifo_rden", 64'(fifo_rden), 64'h0);
        doReset(2);
        clearLogs();
        srcq.push_back({1'b1, 32'h04030201});
        runUntilIdle("post-reset", 20);
        checkVal("post-reset beats", 64'(obsq.size()), 64'd4);
        if (obsq.size() != 0) checkVal("post-reset first", 64'(obsq[0].d), 64'h01);
        checkVal("post-reset count", 64'(beat_count), CNT_EN ? 64'd4 : 64'd0);

        $display("[TB] C_RATIO=1 instance");
        src1.push_back({1'b0, 8'h0A});
        src1.push_back({1'b1, 8'h0B});
        src1.push_back({1'b0, 8'h0C});
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkVal("r1 rden", 64'(s1Rden), 64'(r1Rd[k]));
            checkVal("r1 valid", 64'(s1Valid), 64'(r1Vd[k]));
            if (r1Vd[k]) begin
                checkVal("r1 data", 64'(s1Data), 64'(r1Dt[k]));
                checkVal("r1 last", 64'(s1Last), 64'(r1Lt[k]));
            end
        end
        checkVal("r1 beat_count", 64'(r1_count), CNT_EN ? 64'd3 : 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
